branch_pc_sequencer: RTL

- Next-PC controller for the single-issue MIPS pipeline; owns the PC register.
- Arbitrates redirect requests from the EX-stage conditional branch, the ID-stage jump (J/JAL) and the ID-stage register jump (JR).
- Computes branch targets as PC+4 plus the sign-extended immediate shifted left by 2.
- Sequences the IF/ID and ID/EX flushes that follow every redirect.

---
 rtl/branch_pc_sequencer_if.sv | 34 +++
 rtl/branch_pc_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/branch_pc_sequencer_if.sv
// Request/response bundle between the pipeline and the next-PC sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface branch_pc_sequencer_if;
    logic        stall;
    logic        br_valid;
    logic [2:0]  br_op;
    logic [31:0] br_rs;
    logic [31:0] br_rt;
    logic [31:0] br_pc4;
    logic [31:0] br_imm;
    logic        j_valid;
    logic [25:0] j_index;
    logic [31:0] id_pc4;
    logic        jr_valid;
    logic [31:0] jr_addr;
    logic [31:0] pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        redirect;
    logic [15:0] taken_cnt;
    logic        jr_misalign;

    modport master (
        output stall, br_valid, br_op, br_rs, br_rt, br_pc4, br_imm,
               j_valid, j_index, id_pc4, jr_valid, jr_addr,
        input  pc, flush_if_id, flush_id_ex, redirect, taken_cnt, jr_misalign
    );

    modport slave (
        input  stall, br_valid, br_op, br_rs, br_rt, br_pc4, br_imm,
               j_valid, j_index, id_pc4, jr_valid, jr_addr,
        output pc, flush_if_id, flush_id_ex, redirect, taken_cnt, jr_misalign
    );
endinterface

// File: rtl/branch_pc_sequencer.sv
// Next-PC controller: owns the PC, arbitrates EX branch / ID JR / ID J redirects
// and sequences the pipeline flushes that follow each redirect.
module branch_pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input logic                   clk,
    input logic                   rst,
    branch_pc_sequencer_if.slave  bus
);
    localparam logic [1:0] FLUSH_LOAD = FLUSH_CYCLES[1:0];

    typedef enum logic {RUN, FLUSH} state_t;

    state_t      state, state_nx;
    logic [1:0]  fcnt, fcnt_nx;
    logic [31:0] pc_q, pc_nx;
    logic        fif_q, fif_nx;
    logic        fie_q, fie_nx;
    logic        redir_q, redir_nx;
    logic [15:0] cnt_q, cnt_nx;
    logic        mis_q, mis_nx;

    logic        br_taken;
    logic        take;
    logic [31:0] target;
    logic [31:0] br_target, j_target, jr_target;

    assign br_target = bus.br_pc4 + {bus.br_imm[29:0], 2'b00};
    assign j_target  = {bus.id_pc4[31:28], bus.j_index, 2'b00};
    assign jr_target = {bus.jr_addr[31:2], 2'b00};

    always_comb begin
        br_taken = 1'b0;
        case (bus.br_op)
            3'd0:    br_taken = (bus.br_rs == bus.br_rt);
            3'd1:    br_taken = (bus.br_rs != bus.br_rt);
            3'd2:    br_taken = ($signed(bus.br_rs) <= 0);
            3'd3:    br_taken = ($signed(bus.br_rs) >  0);
            3'd4:    br_taken = ($signed(bus.br_rs) <  0);
            3'd5:    br_taken = ($signed(bus.br_rs) >= 0);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        fcnt_nx  = fcnt;
        pc_nx    = bus.stall ? pc_q : pc_q + 32'd4;
        fif_nx   = 1'b0;
        fie_nx   = 1'b0;
        redir_nx = 1'b0;
        cnt_nx   = cnt_q;
        mis_nx   = mis_q;
        take     = 1'b0;
        target   = pc_q;
        case (state)
            RUN: begin
                // EX branch is the older instruction, so it wins and kills the ID op.
                if (bus.br_valid && br_taken) begin
                    take   = 1'b1;
                    target = br_target;
                    fie_nx = 1'b1;
                end else if (bus.jr_valid) begin
                    take   = 1'b1;
                    target = jr_target;
                    if (bus.jr_addr[1:0] != 2'b00)
                        mis_nx = 1'b1;
                end else if (bus.j_valid) begin
                    take   = 1'b1;
                    target = j_target;
                end
                if (take) begin
                    pc_nx    = target;
                    redir_nx = 1'b1;
                    fif_nx   = 1'b1;
                    state_nx = FLUSH;
                    fcnt_nx  = FLUSH_LOAD;
                    cnt_nx   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                end
            end
            FLUSH: begin
                if (fcnt > 2'd1) begin
                    fcnt_nx = fcnt - 2'd1;
                    fif_nx  = fif_q;
                    fie_nx  = fie_q;
                end else begin
                    fcnt_nx  = 2'd0;
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            fcnt    <= 2'd0;
            pc_q    <= RESET_PC;
            fif_q   <= 1'b0;
            fie_q   <= 1'b0;
            redir_q <= 1'b0;
            cnt_q   <= 16'd0;
            mis_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            fcnt    <= fcnt_nx;
            pc_q    <= pc_nx;
            fif_q   <= fif_nx;
            fie_q   <= fie_nx;
            redir_q <= redir_nx;
            cnt_q   <= cnt_nx;
            mis_q   <= mis_nx;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.flush_if_id = fif_q;
    assign bus.flush_id_ex = fie_q;
    assign bus.redirect    = redir_q;
    assign bus.taken_cnt   = cnt_q;
    assign bus.jr_misalign = mis_q;
endmodule
